// File: rtl/bus_interconnect_mux_if.sv
// Processor-to-slaves bus bundle for bus_interconnect_mux.
// The slave modport is the interconnect's view; master is the processor/slave-array side.
interface bus_interconnect_mux_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  logic                         proc_rd_en_i;
  logic                         proc_wr_en_i;
  logic [ADDR_W-1:0]            proc_addr_i;
  logic [DATA_W-1:0]            proc_data_i;
  logic [DATA_W-1:0]            proc_data_o;
  logic                         proc_ready_o;
  logic                         proc_err_o;
  logic [NUM_SLAVES-1:0]        slv_rd_en_o;
  logic [NUM_SLAVES-1:0]        slv_wr_en_o;
  logic [ADDR_W-1:0]            slv_addr_o;
  logic [DATA_W-1:0]            slv_data_o;
  logic [NUM_SLAVES*DATA_W-1:0] slv_data_i;
  logic [NUM_SLAVES-1:0]        slv_ready_i;

  modport slave (
    input  proc_rd_en_i, proc_wr_en_i, proc_addr_i, proc_data_i, slv_data_i, slv_ready_i,
    output proc_data_o, proc_ready_o, proc_err_o, slv_rd_en_o, slv_wr_en_o, slv_addr_o, slv_data_o
  );

  modport master (
    output proc_rd_en_i, proc_wr_en_i, proc_addr_i, proc_data_i, slv_data_i, slv_ready_i,
    input  proc_data_o, proc_ready_o, proc_err_o, slv_rd_en_o, slv_wr_en_o, slv_addr_o, slv_data_o
  );
endinterface

// File: rtl/bus_interconnect_mux.sv
// Registered address-decoding interconnect: one access at a time to one of NUM_SLAVES regions,
// with bus-error responses for unmapped addresses, rd+wr collisions and stalled slaves.
module bus_interconnect_mux #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SEL_HI     = 31,
  parameter int SEL_LO     = 28,
  parameter logic [NUM_SLAVES*(SEL_HI-SEL_LO+1)-1:0] SLV_SEL = {4'h8, 4'h4, 4'h2, 4'h0},
  parameter int TIMEOUT    = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'h0000_0000
) (
  input logic clk,
  input logic rst_n,
  bus_interconnect_mux_if.slave bus
);
  localparam int SEL_W = SEL_HI - SEL_LO + 1;
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic                  rd_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [DATA_W-1:0]     proc_data_reg;
  logic                  proc_ready_reg;
  logic                  proc_err_reg;
  logic [NUM_SLAVES-1:0] slv_rd_en_reg;
  logic [NUM_SLAVES-1:0] slv_wr_en_reg;
  logic [ADDR_W-1:0]     slv_addr_reg;
  logic [DATA_W-1:0]     slv_data_reg;

  logic [NUM_SLAVES-1:0] hit;
  logic [IDX_W-1:0]      idx_next;
  logic                  match_next;
  logic [NUM_SLAVES-1:0] onehot_next;
  logic                  sel_ready;
  logic [DATA_W-1:0]     sel_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
      assign hit[gi] = (bus.proc_addr_i[SEL_HI:SEL_LO] == SLV_SEL[gi*SEL_W +: SEL_W]);
    end
  endgenerate

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    idx_next   = '0;
    match_next = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        idx_next   = IDX_W'(i);
        match_next = 1'b1;
      end
    end
  end

  assign onehot_next = NUM_SLAVES'(1) << idx_next;
  assign sel_ready   = bus.slv_ready_i[idx_reg];
  assign sel_data    = bus.slv_data_i[idx_reg*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      rd_reg         <= 1'b0;
      cnt_reg        <= '0;
      proc_data_reg  <= '0;
      proc_ready_reg <= 1'b0;
      proc_err_reg   <= 1'b0;
      slv_rd_en_reg  <= '0;
      slv_wr_en_reg  <= '0;
      slv_addr_reg   <= '0;
      slv_data_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          proc_ready_reg <= 1'b0;
          proc_err_reg   <= 1'b0;
          cnt_reg        <= '0;
          if (bus.proc_rd_en_i || bus.proc_wr_en_i) begin
            slv_addr_reg <= bus.proc_addr_i;
            slv_data_reg <= bus.proc_data_i;
            rd_reg       <= bus.proc_rd_en_i && !bus.proc_wr_en_i;
            idx_reg      <= idx_next;
            if (bus.proc_rd_en_i && bus.proc_wr_en_i) begin
              // Ambiguous op: reject without touching any slave or the read data.
              proc_ready_reg <= 1'b1;
              proc_err_reg   <= 1'b1;
              state_reg      <= RESP;
            end else if (!match_next) begin
              proc_ready_reg <= 1'b1;
              proc_err_reg   <= 1'b1;
              if (bus.proc_rd_en_i) proc_data_reg <= ERR_DATA;
              state_reg      <= RESP;
            end else begin
              slv_rd_en_reg <= bus.proc_rd_en_i ? onehot_next : '0;
              slv_wr_en_reg <= bus.proc_wr_en_i ? onehot_next : '0;
              state_reg     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // Ready is checked before the terminal count so a last-cycle completion is not an error.
          if (sel_ready) begin
            slv_rd_en_reg  <= '0;
            slv_wr_en_reg  <= '0;
            if (rd_reg) proc_data_reg <= sel_data;
            proc_ready_reg <= 1'b1;
            proc_err_reg   <= 1'b0;
            state_reg      <= RESP;
          end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            slv_rd_en_reg  <= '0;
            slv_wr_en_reg  <= '0;
            if (rd_reg) proc_data_reg <= ERR_DATA;
            proc_ready_reg <= 1'b1;
            proc_err_reg   <= 1'b1;
            state_reg      <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESP: begin
          proc_ready_reg <= 1'b0;
          proc_err_reg   <= 1'b0;
          cnt_reg        <= '0;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.proc_data_o  = proc_data_reg;
  assign bus.proc_ready_o = proc_ready_reg;
  assign bus.proc_err_o   = proc_err_reg;
  assign bus.slv_rd_en_o  = slv_rd_en_reg;
  assign bus.slv_wr_en_o  = slv_wr_en_reg;
  assign bus.slv_addr_o   = slv_addr_reg;
  assign bus.slv_data_o   = slv_data_reg;
endmodule

// File: doc/bus_interconnect_mux.md
Name: bus_interconnect_mux

Overview:
- Parametrised, registered successor to the two-region processor bus splitter.
- Decodes the processor address against NUM_SLAVES programmable regions and forwards one access at a time to the selected slave.
- Waits on a per-slave ready handshake and returns registered read data with a ready/error response.
- Unmapped addresses and slaves that stall past a timeout return a bus error instead of hanging the core.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- SEL_HI, 31, MSB of the region-select field in the address.
- SEL_LO, 28, LSB of the region-select field; SEL_W = SEL_HI-SEL_LO+1.
- SLV_SEL, {4'h8,4'h4,4'h2,4'h0}, concatenated select values; slave i owns SLV_SEL[i*SEL_W +: SEL_W].
- TIMEOUT, 16, maximum cycles spent in ACCESS before an error response (>=2).
- ERR_DATA, 32'h0000_0000, value placed on proc_data_o for errored reads.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- proc_rd_en_i  in  1  processor read request.
- proc_wr_en_i  in  1  processor write request.
- proc_addr_i  in  ADDR_W  processor address.
- proc_data_i  in  DATA_W  processor write data.
- proc_data_o  out  DATA_W  registered read data.
- proc_ready_o  out  1  one-cycle response strobe.
- proc_err_o  out  1  error qualifier, valid with proc_ready_o.
- slv_rd_en_o  out  NUM_SLAVES  per-slave read enable.
- slv_wr_en_o  out  NUM_SLAVES  per-slave write enable.
- slv_addr_o  out  ADDR_W  latched address, broadcast to all slaves.
- slv_data_o  out  DATA_W  latched write data, broadcast to all slaves.
- slv_data_i  in  NUM_SLAVES*DATA_W  slave read data; slave i occupies [i*DATA_W +: DATA_W].
- slv_ready_i  in  NUM_SLAVES  slave completion; combinational ready is allowed.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: all outputs 0, FSM in IDLE, timeout counter 0. Reset asserted mid-access aborts the access with no response; slave enables drop immediately.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - When rd or wr is asserted, latch addr, data, op and decoded slave index.
  - Decode: slave i hits when proc_addr_i[SEL_HI:SEL_LO] == its SLV_SEL field; lowest matching index wins.
  - rd and wr both high -> error, no slave access, go to RESP.
  - No match (unmapped) -> error, go to RESP.
  - Otherwise go to ACCESS.
- ACCESS:
  - Drive only the latched slave's enable for the latched op, plus slv_addr_o/slv_data_o; hold until that slave's slv_ready_i is high.
  - On ready: capture slv_data_i of that slave into proc_data_o (reads only; writes leave proc_data_o unchanged), err=0, go to RESP.
  - Counter increments each ACCESS cycle. When it reaches TIMEOUT-1 with ready still low: err=1, proc_data_o=ERR_DATA if the op is a read, go to RESP.
  - Ready arriving in the same cycle as the timeout terminal count wins (no error).
  - Ready from non-selected slaves is ignored.
- RESP:
  - proc_ready_o=1 for exactly one cycle; proc_err_o is valid during that cycle and 0 at all other times.
  - All slave enables are 0; counter clears; return to IDLE.
- Latency: with a zero-wait slave, request in cycle 0 -> ACCESS in cycle 1 -> proc_ready_o in cycle 2. An error decoded in IDLE responds in cycle 1.
- Back-to-back: an enable still high in the cycle after RESP is treated as a new request.
- Input changes during ACCESS/RESP are ignored.
- proc_data_o holds its last value until the next read completion.
- slv_addr_o/slv_data_o hold their latched values outside ACCESS; only the enables qualify them.

Test Plan:
- Reset: assert rst_n=0 mid-ACCESS -> all enables, proc_ready_o and proc_err_o go to 0 asynchronously; after release the FSM is in IDLE.
- Zero-wait read: addr 0x8000_0010 to slave 3 (SLV_SEL 8), slv_ready_i[3]=1, slv_data_i slot 3=0xCAFE_F00D -> slv_rd_en_o=4'b1000 for 1 cycle; proc_ready_o=1, proc_err_o=0, proc_data_o=0xCAFE_F00D in cycle 2.
- Wait-state write: addr 0x2000_0004, data 0x1234_5678, ready after 3 cycles -> slv_wr_en_o[1] high 3 cycles, slv_data_o=0x1234_5678; ready/no-error response; proc_data_o unchanged.
- Unmapped read: addr 0xF000_0000 -> no slave enable; proc_ready_o=1 and proc_err_o=1 in cycle 1; proc_data_o=ERR_DATA.
- Timeout: slave 0 never ready -> enable held for TIMEOUT (16) cycles, then an error response; the next request is serviced normally.
- Boundary cases:
  - Ready on the terminal-count cycle -> no error.
  - rd and wr both high -> error response in cycle 1, no enables.
  - Back-to-back reads to slaves 0 and 3 -> two distinct responses, 3 cycles apart.
